// File: rtl/fwd_source_pipe_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fwd_source_pipe_if
//  Brief    : Bus bundle between the execute stage, data memory, the register
//             file and the operand-forwarding source pipe.
//             FWD_STALL_CNT_EN adds the STALL_COUNT signal.
//  Revision : 1.0  initial release
// ============================================================================
interface fwd_source_pipe_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic              HOLD;
   logic              EX_WR_EN;
   logic [ADDR_W-1:0] EX_WR_ADDR;
   logic [DATA_W-1:0] EX_WR_DATA;
   logic              EX_IS_LOAD;
   logic [DATA_W-1:0] MEM_LOAD_DATA;
   logic [ADDR_W-1:0] RD_ADDR_A;
   logic [ADDR_W-1:0] RD_ADDR_B;
   logic              FWD_EN_A;
   logic              FWD_EN_B;
   logic [DATA_W-1:0] FWD_DATA_A;
   logic [DATA_W-1:0] FWD_DATA_B;
   logic              LOAD_USE_STALL;
   logic              RF_WR_EN;
   logic [ADDR_W-1:0] RF_WR_ADDR;
   logic [DATA_W-1:0] RF_WR_DATA;
`ifdef FWD_STALL_CNT_EN
   logic [15:0]       STALL_COUNT;

   modport master (
      output HOLD, EX_WR_EN, EX_WR_ADDR, EX_WR_DATA, EX_IS_LOAD, MEM_LOAD_DATA,
             RD_ADDR_A, RD_ADDR_B,
      input  FWD_EN_A, FWD_EN_B, FWD_DATA_A, FWD_DATA_B, LOAD_USE_STALL,
             RF_WR_EN, RF_WR_ADDR, RF_WR_DATA, STALL_COUNT
   );

   modport slave (
      input  HOLD, EX_WR_EN, EX_WR_ADDR, EX_WR_DATA, EX_IS_LOAD, MEM_LOAD_DATA,
             RD_ADDR_A, RD_ADDR_B,
      output FWD_EN_A, FWD_EN_B, FWD_DATA_A, FWD_DATA_B, LOAD_USE_STALL,
             RF_WR_EN, RF_WR_ADDR, RF_WR_DATA, STALL_COUNT
   );
`else
   modport master (
      output HOLD, EX_WR_EN, EX_WR_ADDR, EX_WR_DATA, EX_IS_LOAD, MEM_LOAD_DATA,
             RD_ADDR_A, RD_ADDR_B,
      input  FWD_EN_A, FWD_EN_B, FWD_DATA_A, FWD_DATA_B, LOAD_USE_STALL,
             RF_WR_EN, RF_WR_ADDR, RF_WR_DATA
   );

   modport slave (
      input  HOLD, EX_WR_EN, EX_WR_ADDR, EX_WR_DATA, EX_IS_LOAD, MEM_LOAD_DATA,
             RD_ADDR_A, RD_ADDR_B,
      output FWD_EN_A, FWD_EN_B, FWD_DATA_A, FWD_DATA_B, LOAD_USE_STALL,
             RF_WR_EN, RF_WR_ADDR, RF_WR_DATA
   );
`endif
endinterface
`default_nettype wire

// File: rtl/fwd_source_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fwd_source_pipe
//  Brief    : MEM/WB pending-write tracker: commits to the register file,
//             resolves forwarding for two EX operand ports, raises load-use.
//             FWD_STALL_CNT_EN adds a saturating 16-bit load-use counter.
//  Revision : 1.0  initial release
// ============================================================================
module fwd_source_pipe #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  wire logic         CLK,
   input  wire logic         RST,
   fwd_source_pipe_if.slave  bus
);

   logic              r_memValid;
   logic [ADDR_W-1:0] r_memAddr;
   logic [DATA_W-1:0] r_memData;
   logic              r_memIsLoad;
   logic              r_wbValid;
   logic [ADDR_W-1:0] r_wbAddr;
   logic [DATA_W-1:0] r_wbData;

   logic              w_memAddrEqA;
   logic              w_memAddrEqB;
   logic              w_hitMemA;
   logic              w_hitMemB;
   logic              w_loadMatchA;
   logic              w_loadMatchB;
   logic              w_hitWbA;
   logic              w_hitWbB;
   logic              w_stall;
   logic [DATA_W-1:0] w_wbNextData;

   assign w_memAddrEqA = (r_memAddr == bus.RD_ADDR_A);
   assign w_memAddrEqB = (r_memAddr == bus.RD_ADDR_B);

   assign w_hitMemA    = r_memValid & w_memAddrEqA & ~r_memIsLoad;
   assign w_hitMemB    = r_memValid & w_memAddrEqB & ~r_memIsLoad;
   assign w_loadMatchA = r_memValid & w_memAddrEqA &  r_memIsLoad;
   assign w_loadMatchB = r_memValid & w_memAddrEqB &  r_memIsLoad;

   // A MEM-stage load is the newest writer, so an older WB entry must not leak through.
   assign w_hitWbA = r_wbValid & (r_wbAddr == bus.RD_ADDR_A) & ~w_loadMatchA;
   assign w_hitWbB = r_wbValid & (r_wbAddr == bus.RD_ADDR_B) & ~w_loadMatchB;

   assign w_stall      = w_loadMatchA | w_loadMatchB;
   assign w_wbNextData = r_memIsLoad ? bus.MEM_LOAD_DATA : r_memData;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_memValid  <= 1'b0;
         r_memAddr   <= '0;
         r_memData   <= '0;
         r_memIsLoad <= 1'b0;
         r_wbValid   <= 1'b0;
         r_wbAddr    <= '0;
         r_wbData    <= '0;
      end else if (!bus.HOLD) begin
         r_wbValid <= r_memValid;
         r_wbAddr  <= r_memAddr;
         r_wbData  <= w_wbNextData;
         if (w_stall) begin
            r_memValid  <= 1'b0;
            r_memAddr   <= '0;
            r_memData   <= '0;
            r_memIsLoad <= 1'b0;
         end else begin
            r_memValid  <= bus.EX_WR_EN;
            r_memAddr   <= bus.EX_WR_ADDR;
            r_memData   <= bus.EX_WR_DATA;
            r_memIsLoad <= bus.EX_IS_LOAD;
         end
      end
   end

   always_comb begin
      bus.FWD_EN_A   = w_hitMemA | w_hitWbA;
      bus.FWD_DATA_A = '0;
      if (w_hitMemA)
         bus.FWD_DATA_A = r_memData;
      else if (w_hitWbA)
         bus.FWD_DATA_A = r_wbData;
   end

   always_comb begin
      bus.FWD_EN_B   = w_hitMemB | w_hitWbB;
      bus.FWD_DATA_B = '0;
      if (w_hitMemB)
         bus.FWD_DATA_B = r_memData;
      else if (w_hitWbB)
         bus.FWD_DATA_B = r_wbData;
   end

   assign bus.LOAD_USE_STALL = w_stall;
   assign bus.RF_WR_EN       = r_wbValid & ~bus.HOLD;
   assign bus.RF_WR_ADDR     = r_wbAddr;
   assign bus.RF_WR_DATA     = r_wbData;

`ifdef FWD_STALL_CNT_EN
   localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

   logic [15:0] r_stallCount;

   always_ff @(posedge CLK) begin
      if (RST)
         r_stallCount <= '0;
      else if (w_stall && !bus.HOLD && (r_stallCount != c_CNT_MAX))
         r_stallCount <= r_stallCount + 16'd1;
   end

   assign bus.STALL_COUNT = r_stallCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_source_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fwd_source_pipe
//  Brief    : Self-checking bench for fwd_source_pipe against an age-ordered
//             history model of in-flight writes (FWD_STALL_CNT_EN aware).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fwd_source_pipe;
   localparam int AW = 5;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fwd_source_pipe_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   fwd_source_pipe #(.ADDR_W(AW), .DATA_W(DW)) dut (.CLK(clk), .RST(rst), .bus(bus));

   typedef struct {
      bit          v;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bit          ld;
   } ent_t;

   // hist[0] = newest in-flight write (one cycle past EX), hist[1] = the one before
   ent_t        hist[$];
   int          nVec = 0;
   int          nErr = 0;
   int unsigned mCount = 0;

   function automatic ent_t bubble();
      ent_t e;
      e.v = 0; e.a = '0; e.d = '0; e.ld = 0;
      return e;
   endfunction

   task automatic model_reset();
      hist.delete();
      hist.push_back(bubble());
      hist.push_back(bubble());
      mCount = 0;
   endtask

   function automatic bit model_stall(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
      return hist[0].v && hist[0].ld && (hist[0].a == ra || hist[0].a == rb);
   endfunction

   // Newest matching writer wins; an unresolved load yields no forward.
   function automatic void model_fwd(input logic [AW-1:0] ra, output bit en, output logic [DW-1:0] d);
      en = 0; d = '0;
      for (int i = 0; i < 2; i++) begin
         if (hist[i].v && hist[i].a == ra) begin
            if (!hist[i].ld) begin
               en = 1; d = hist[i].d;
            end
            return;
         end
      end
   endfunction

   task automatic drive(input bit en, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit ld);
      bus.EX_WR_EN = en; bus.EX_WR_ADDR = a; bus.EX_WR_DATA = d; bus.EX_IS_LOAD = ld;
   endtask

   task automatic tick();
      bit st, h, r;
      ent_t n, m;
      logic [DW-1:0] ldd;
      st = model_stall(bus.RD_ADDR_A, bus.RD_ADDR_B);
      n.v = bus.EX_WR_EN; n.a = bus.EX_WR_ADDR; n.d = bus.EX_WR_DATA; n.ld = bus.EX_IS_LOAD;
      ldd = bus.MEM_LOAD_DATA; h = bus.HOLD; r = rst;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else if (!h) begin
         if (st && mCount < 65535) mCount++;
         m = hist[0];
         if (m.ld) begin m.d = ldd; m.ld = 0; end
         hist.delete();
         hist.push_back(st ? bubble() : n);
         hist.push_back(m);
      end
      #1;
   endtask

   task automatic idle(input int n);
      drive(0, '0, '0, 0);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, AW'(i + 1), DW'(8'h40 + i), 0);
         tick();
      end
      drive(0, '0, '0, 0);
      bus.RD_ADDR_A = 5'd3; bus.RD_ADDR_B = 5'd2;
      rst = 1'b1; tick(); rst = 1'b0; #1;
      nVec++;
      if ({bus.RF_WR_EN, bus.FWD_EN_A, bus.FWD_EN_B, bus.LOAD_USE_STALL} !== 4'b0000) begin
         nErr++; $display("FAIL reset_flags got %b want 0000", {bus.RF_WR_EN, bus.FWD_EN_A, bus.FWD_EN_B, bus.LOAD_USE_STALL});
      end
      nVec++;
      if ({bus.RF_WR_ADDR, bus.RF_WR_DATA, bus.FWD_DATA_A, bus.FWD_DATA_B} !== '0) begin
         nErr++; $display("FAIL reset_fields got %h/%h/%h/%h want all 0", bus.RF_WR_ADDR, bus.RF_WR_DATA, bus.FWD_DATA_A, bus.FWD_DATA_B);
      end
      tick(); #1;
      nVec++;
      if (bus.RF_WR_EN !== 1'b0) begin
         nErr++; $display("FAIL reset_no_commit got %b want 0", bus.RF_WR_EN);
      end
   endtask

   task automatic test_alu_chain();
      idle(2);
      bus.RD_ADDR_A = 5'd20; bus.RD_ADDR_B = 5'd21;
      drive(1, 5'd3, 8'h12, 0); tick();
      drive(1, 5'd3, 8'h34, 0); tick();
      drive(0, '0, '0, 0);
      bus.RD_ADDR_A = 5'd3; #1;
      nVec++;
      if ({bus.FWD_EN_A, bus.FWD_DATA_A} !== {1'b1, 8'h34}) begin
         nErr++; $display("FAIL alu_mem_priority got %b/%h want 1/34", bus.FWD_EN_A, bus.FWD_DATA_A);
      end
      nVec++;
      if ({bus.RF_WR_EN, bus.RF_WR_ADDR, bus.RF_WR_DATA} !== {1'b1, 5'd3, 8'h12}) begin
         nErr++; $display("FAIL alu_commit1 got %b/%h/%h want 1/03/12", bus.RF_WR_EN, bus.RF_WR_ADDR, bus.RF_WR_DATA);
      end
      tick(); #1;
      nVec++;
      if ({bus.RF_WR_EN, bus.RF_WR_ADDR, bus.RF_WR_DATA} !== {1'b1, 5'd3, 8'h34}) begin
         nErr++; $display("FAIL alu_commit2 got %b/%h/%h want 1/03/34", bus.RF_WR_EN, bus.RF_WR_ADDR, bus.RF_WR_DATA);
      end
      nVec++;
      if ({bus.FWD_EN_A, bus.FWD_DATA_A} !== {1'b1, 8'h34}) begin
         nErr++; $display("FAIL alu_wb_fwd got %b/%h want 1/34", bus.FWD_EN_A, bus.FWD_DATA_A);
      end
   endtask

   task automatic test_load_use();
      idle(2);
      bus.RD_ADDR_A = 5'd20; bus.RD_ADDR_B = 5'd21;
      drive(1, 5'd5, 8'hEE, 1); tick();
      drive(1, 5'd9, 8'h11, 0);
      bus.RD_ADDR_B = 5'd5; bus.MEM_LOAD_DATA = 8'hA7; #1;
      nVec++;
      if ({bus.LOAD_USE_STALL, bus.FWD_EN_B} !== 2'b10) begin
         nErr++; $display("FAIL load_stall got stall=%b en=%b want 1/0", bus.LOAD_USE_STALL, bus.FWD_EN_B);
      end
      tick(); bus.MEM_LOAD_DATA = 8'h00; #1;
      nVec++;
      if ({bus.LOAD_USE_STALL, bus.FWD_EN_B, bus.FWD_DATA_B} !== {2'b01, 8'hA7}) begin
         nErr++; $display("FAIL load_fwd got stall=%b en=%b data=%h want 0/1/a7", bus.LOAD_USE_STALL, bus.FWD_EN_B, bus.FWD_DATA_B);
      end
      nVec++;
      if ({bus.RF_WR_EN, bus.RF_WR_ADDR, bus.RF_WR_DATA} !== {1'b1, 5'd5, 8'hA7}) begin
         nErr++; $display("FAIL load_commit got %b/%h/%h want 1/05/a7", bus.RF_WR_EN, bus.RF_WR_ADDR, bus.RF_WR_DATA);
      end
      drive(0, '0, '0, 0); tick(); #1;
      nVec++;
      if (bus.RF_WR_EN !== 1'b0) begin
         nErr++; $display("FAIL load_bubble got %b want 0", bus.RF_WR_EN);
      end
   endtask

   task automatic test_dual_port();
      idle(2);
      drive(1, 5'd2, 8'h02, 0); tick();
      drive(1, 5'd1, 8'h01, 0); tick();
      drive(0, '0, '0, 0);
      bus.RD_ADDR_A = 5'd1; bus.RD_ADDR_B = 5'd2; #1;
      nVec++;
      if ({bus.FWD_EN_A, bus.FWD_DATA_A, bus.FWD_EN_B, bus.FWD_DATA_B} !== {1'b1, 8'h01, 1'b1, 8'h02}) begin
         nErr++; $display("FAIL dual_fwd got %b/%h %b/%h want 1/01 1/02", bus.FWD_EN_A, bus.FWD_DATA_A, bus.FWD_EN_B, bus.FWD_DATA_B);
      end
      bus.RD_ADDR_A = 5'd7; #1;
      nVec++;
      if ({bus.FWD_EN_A, bus.FWD_EN_B} !== 2'b01) begin
         nErr++; $display("FAIL dual_miss got %b%b want 01", bus.FWD_EN_A, bus.FWD_EN_B);
      end
   endtask

   task automatic test_hold();
      int commits;
      idle(2);
      bus.RD_ADDR_A = 5'd4; bus.RD_ADDR_B = 5'd21;
      drive(1, 5'd4, 8'h55, 0); tick();
      drive(0, '0, '0, 0); tick();
      bus.HOLD = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         nVec++;
         if ({bus.RF_WR_EN, bus.FWD_EN_A, bus.FWD_DATA_A} !== {2'b01, 8'h55}) begin
            nErr++; $display("FAIL hold_cycle%0d got wr=%b en=%b data=%h want 0/1/55", i, bus.RF_WR_EN, bus.FWD_EN_A, bus.FWD_DATA_A);
         end
         tick();
      end
      bus.HOLD = 1'b0;
      commits = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (bus.RF_WR_EN === 1'b1) begin
            commits++;
            nVec++;
            if ({bus.RF_WR_ADDR, bus.RF_WR_DATA} !== {5'd4, 8'h55}) begin
               nErr++; $display("FAIL hold_commit_val got %h/%h want 04/55", bus.RF_WR_ADDR, bus.RF_WR_DATA);
            end
         end
         tick();
      end
      nVec++;
      if (commits != 1) begin
         nErr++; $display("FAIL hold_commit_count got %0d want 1", commits);
      end
   endtask

   task automatic test_random();
      bit eA, eB, eSt;
      logic [DW-1:0] dA, dB;
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 59) == 0);
         bus.HOLD = ($urandom_range(0, 7) == 0);
         drive($urandom_range(0, 3) != 0, AW'($urandom_range(0, 5)), DW'($urandom), $urandom_range(0, 3) == 0);
         bus.RD_ADDR_A = AW'($urandom_range(0, 5));
         bus.RD_ADDR_B = AW'($urandom_range(0, 5));
         bus.MEM_LOAD_DATA = DW'($urandom);
         #1;
         eSt = model_stall(bus.RD_ADDR_A, bus.RD_ADDR_B);
         model_fwd(bus.RD_ADDR_A, eA, dA);
         model_fwd(bus.RD_ADDR_B, eB, dB);
         nVec++;
         if (bus.LOAD_USE_STALL !== eSt) begin
            nErr++; $display("FAIL rnd_stall c=%0d got %b want %b", c, bus.LOAD_USE_STALL, eSt);
         end
         nVec++;
         if (bus.FWD_EN_A !== eA || (eA && bus.FWD_DATA_A !== dA)) begin
            nErr++; $display("FAIL rnd_fwd_a c=%0d got %b/%h want %b/%h", c, bus.FWD_EN_A, bus.FWD_DATA_A, eA, dA);
         end
         nVec++;
         if (bus.FWD_EN_B !== eB || (eB && bus.FWD_DATA_B !== dB)) begin
            nErr++; $display("FAIL rnd_fwd_b c=%0d got %b/%h want %b/%h", c, bus.FWD_EN_B, bus.FWD_DATA_B, eB, dB);
         end
         nVec++;
         if (bus.RF_WR_EN !== (hist[1].v & ~bus.HOLD) ||
             (hist[1].v && {bus.RF_WR_ADDR, bus.RF_WR_DATA} !== {hist[1].a, hist[1].d})) begin
            nErr++; $display("FAIL rnd_commit c=%0d got %b/%h/%h want %b/%h/%h", c, bus.RF_WR_EN, bus.RF_WR_ADDR,
                             bus.RF_WR_DATA, hist[1].v & ~bus.HOLD, hist[1].a, hist[1].d);
         end
`ifdef FWD_STALL_CNT_EN
         nVec++;
         if (bus.STALL_COUNT !== 16'(mCount)) begin
            nErr++; $display("FAIL rnd_stall_count c=%0d got %0d want %0d", c, bus.STALL_COUNT, mCount);
         end
`endif
         tick();
      end
      rst = 1'b0; bus.HOLD = 1'b0;
   endtask

`ifdef FWD_STALL_CNT_EN
   task automatic test_stall_count();
      drive(0, '0, '0, 0);
      bus.RD_ADDR_A = 5'd20; bus.RD_ADDR_B = 5'd21;
      rst = 1'b1; tick(); rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(1, AW'(10 + k), 8'h00, 1); tick();
         drive(0, '0, '0, 0);
         bus.RD_ADDR_A = AW'(10 + k);
         if (k == 2) begin
            bus.HOLD = 1'b1; tick();
            bus.HOLD = 1'b0; bus.RD_ADDR_A = 5'd20;
         end
         tick();
         bus.RD_ADDR_A = 5'd20;
         tick();
      end
      #1;
      nVec++;
      if (bus.STALL_COUNT !== 16'd3) begin
         nErr++; $display("FAIL stall_count got %0d want 3", bus.STALL_COUNT);
      end
   endtask
`endif

   initial begin
      bus.HOLD = 1'b0;
      bus.MEM_LOAD_DATA = '0;
      bus.RD_ADDR_A = '0;
      bus.RD_ADDR_B = '0;
      drive(0, '0, '0, 0);
      model_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      test_reset();
      test_alu_chain();
      test_load_use();
      test_dual_port();
      test_hold();
`ifdef FWD_STALL_CNT_EN
      test_stall_count();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end
endmodule
`default_nettype wire
